frank_sequencer: RTL and testbench

Multi-cycle fetch/execute sequencer for the FRANK 8-bit processor. It fetches 16-bit instructions from program memory over a req/ack handshake and drives opcode and operands into the combinational ALU. It writes the ALU result and status back into the W register and status register, and resolves conditional jumps on the stored flags. The block sits directly upstream and downstream of the ALU: it feeds it and consumes its result in the same cycle.

---
 rtl/frank_pkg.sv | 32 +++
 rtl/frank_decode.sv | 33 +++
 rtl/frank_sequencer.sv | 96 +++++++++
 tb/tb_frank_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/frank_pkg.sv
// Shared definitions for the FRANK fetch/execute sequencer: instruction classes,
// FSM state encoding and status-bit positions.
package frank_pkg;

  localparam logic [3:0] CLS_ALUI = 4'd0;
  localparam logic [3:0] CLS_LDI  = 4'd1;
  localparam logic [3:0] CLS_JMP  = 4'd2;
  localparam logic [3:0] CLS_JZ   = 4'd3;
  localparam logic [3:0] CLS_JN   = 4'd4;
  localparam logic [3:0] CLS_JC   = 4'd5;
  localparam logic [3:0] CLS_HALT = 4'd6;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  localparam int ST_Z = 0;
  localparam int ST_N = 1;
  localparam int ST_C = 2;

  // Flags produced by a load-immediate: carry cleared, sign and zero from the value.
  function automatic logic [2:0] ldi_status(input logic [7:0] imm);
    logic [2:0] st;
    st       = 3'b000;
    st[ST_N] = imm[7];
    st[ST_Z] = (imm == 8'h00);
    return st;
  endfunction

endpackage

// File: rtl/frank_decode.sv
// Combinational instruction decode: turns the instruction class and the stored
// flags into write enables, jump resolution and the halt request.
module frank_decode
  import frank_pkg::*;
(
  input  logic [3:0] cls,
  input  logic [2:0] status,
  output logic       we_w,
  output logic       we_status,
  output logic       take_jump,
  output logic       halt
);

  always_comb begin
    we_w      = 1'b0;
    we_status = 1'b0;
    take_jump = 1'b0;
    halt      = 1'b0;
    case (cls)
      CLS_ALUI, CLS_LDI: begin
        we_w      = 1'b1;
        we_status = 1'b1;
      end
      CLS_JMP:  take_jump = 1'b1;
      CLS_JZ:   take_jump = status[ST_Z];
      CLS_JN:   take_jump = status[ST_N];
      CLS_JC:   take_jump = status[ST_C];
      CLS_HALT: halt      = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/frank_sequencer.sv
// FRANK fetch/execute sequencer: fetches 16-bit words over req/ack, feeds the
// external combinational ALU and writes results back in a single EXEC cycle.
module frank_sequencer
  import frank_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic [3:0]  alu_opcode,
  output logic [7:0]  alu_w,
  output logic [7:0]  alu_p,
  input  logic [7:0]  alu_res,
  input  logic [2:0]  alu_status,
  output logic [7:0]  wreg,
  output logic [2:0]  status,
  output logic [7:0]  pc,
  output logic        halted
);

  state_t      state, state_nxt;
  logic [15:0] ir, ir_nxt;
  logic [7:0]  pc_nxt, wreg_nxt;
  logic [2:0]  status_nxt;
  logic [3:0]  cls;
  logic [7:0]  imm;
  logic        we_w, we_status, take_jump, halt;

  assign cls = ir[15:12];
  assign imm = ir[7:0];

  frank_decode u_decode (
    .cls       (cls),
    .status    (status),
    .we_w      (we_w),
    .we_status (we_status),
    .take_jump (take_jump),
    .halt      (halt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_FETCH;
      ir     <= 16'h0000;
      pc     <= 8'h00;
      wreg   <= 8'h00;
      status <= 3'b000;
    end else begin
      state  <= state_nxt;
      ir     <= ir_nxt;
      pc     <= pc_nxt;
      wreg   <= wreg_nxt;
      status <= status_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    ir_nxt     = ir;
    pc_nxt     = pc;
    wreg_nxt   = wreg;
    status_nxt = status;
    case (state)
      S_FETCH: begin
        if (imem_ack) begin
          ir_nxt    = imem_data;
          pc_nxt    = pc + 8'd1;
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        // pc already points past this instruction; a taken jump replaces it.
        if (we_w)
          wreg_nxt = (cls == CLS_LDI) ? imm : alu_res;
        if (we_status)
          status_nxt = (cls == CLS_LDI) ? ldi_status(imm) : alu_status;
        if (take_jump)
          pc_nxt = imm;
        state_nxt = halt ? S_HALT : S_FETCH;
      end
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_FETCH;
    endcase
  end

  // The reset term drops the request combinationally while rst_n is held low.
  assign imem_req   = rst_n & (state == S_FETCH);
  assign imem_addr  = pc;
  assign alu_opcode = ir[11:8];
  assign alu_w      = wreg;
  assign alu_p      = imm;
  assign halted     = (state == S_HALT);

endmodule

// File: tb/tb_frank_sequencer.sv
// Bench for frank_sequencer: memory and ALU models around the DUT, plus an
// instruction-level reference model of the architectural state.
module tb_frank_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic [3:0]  alu_opcode;
  logic [7:0]  alu_w, alu_p, alu_res;
  logic [2:0]  alu_status;
  logic [7:0]  wreg, pc;
  logic [2:0]  status;
  logic        halted;

  always #5 clk = ~clk;

  frank_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_data  (imem_data),
    .alu_opcode (alu_opcode),
    .alu_w      (alu_w),
    .alu_p      (alu_p),
    .alu_res    (alu_res),
    .alu_status (alu_status),
    .wreg       (wreg),
    .status     (status),
    .pc         (pc),
    .halted     (halted)
  );

  localparam logic [3:0] OP_ADDWP = 4'h1;

  // Bench ALU: returns {result, C, N, Z}.
  function automatic logic [10:0] alu_model(input logic [3:0] op, input logic [7:0] w,
                                            input logic [7:0] p);
    logic [8:0] r;
    case (op)
      4'h0:     r = {1'b0, p};
      4'h1:     r = {1'b0, w} + {1'b0, p};
      4'h2:     r = {1'b0, w} - {1'b0, p};
      4'h3:     r = {1'b0, w & p};
      4'h4:     r = {1'b0, w | p};
      4'h5:     r = {1'b0, w ^ p};
      default:  r = {1'b0, w};
    endcase
    return {r[7:0], r[8], r[7], r[7:0] == 8'h00};
  endfunction

  assign {alu_res, alu_status} = alu_model(alu_opcode, alu_w, alu_p);

  logic [15:0] mem [256];
  logic [7:0]  m_pc, m_w;
  logic [2:0]  m_st;
  logic [15:0] m_ir;
  bit          m_halt;
  int          errs = 0;
  int          checks = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 8'h00; m_w = 8'h00; m_st = 3'b000; m_ir = 16'h0000; m_halt = 1'b0;
  endtask

  // Architectural effect of one whole instruction at m_pc.
  task automatic model_exec();
    logic [7:0]  imm;
    logic [10:0] r;
    m_ir = mem[m_pc];
    m_pc = m_pc + 8'd1;
    imm  = m_ir[7:0];
    case (m_ir[15:12])
      4'd0: begin r = alu_model(m_ir[11:8], m_w, imm); m_w = r[10:3]; m_st = r[2:0]; end
      4'd1: begin m_w = imm; m_st = {1'b0, imm[7], imm == 8'h00}; end
      4'd2: m_pc = imm;
      4'd3: if (m_st[0]) m_pc = imm;
      4'd4: if (m_st[1]) m_pc = imm;
      4'd5: if (m_st[2]) m_pc = imm;
      4'd6: m_halt = 1'b1;
      default: ;
    endcase
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_req",    {15'd0, imem_req}, 16'h0000);
    chk("rst_pc",     {8'd0, pc},        16'h0000);
    chk("rst_wreg",   {8'd0, wreg},      16'h0000);
    chk("rst_status", {13'd0, status},   16'h0000);
    chk("rst_halted", {15'd0, halted},   16'h0000);
    chk("rst_ir",     {4'd0, alu_opcode, alu_p}, 16'h0000);
    cyc();
    cyc();
    rst_n = 1'b0;
    rst_n = 1'b1;
    #1;
    model_reset();
    chk("rel_req",  {15'd0, imem_req}, 16'h0001);
    chk("rel_addr", {8'd0, imem_addr}, 16'h0000);
  endtask

  task automatic run_instr(input int wait_cyc, input bit spurious);
    chk("fetch_req",  {15'd0, imem_req}, 16'h0001);
    chk("fetch_addr", {8'd0, imem_addr}, {8'd0, m_pc});
    for (int k = 0; k < wait_cyc; k++) begin
      imem_ack  = 1'b0;
      imem_data = 16'($urandom);
      cyc();
      chk("wait_req",  {15'd0, imem_req}, 16'h0001);
      chk("wait_addr", {8'd0, imem_addr}, {8'd0, m_pc});
      chk("wait_ir",   {4'd0, alu_opcode, alu_p}, {4'd0, m_ir[11:0]});
    end
    imem_ack  = 1'b1;
    imem_data = mem[m_pc];
    cyc();
    imem_ack  = 1'b0;
    chk("exec_req", {15'd0, imem_req}, 16'h0000);
    chk("exec_ir",  {4'd0, alu_opcode, alu_p}, {4'd0, mem[m_pc][11:0]});
    chk("exec_pc",  {8'd0, pc}, {8'd0, m_pc + 8'd1});
    if (spurious) begin
      imem_ack  = 1'b1;
      imem_data = 16'($urandom);
    end
    cyc();
    imem_ack = 1'b0;
    model_exec();
    chk("res_wreg",   {8'd0, wreg},    {8'd0, m_w});
    chk("res_status", {13'd0, status}, {13'd0, m_st});
    chk("res_pc",     {8'd0, pc},      {8'd0, m_pc});
    chk("res_halted", {15'd0, halted}, {15'd0, m_halt});
    chk("res_ir",     {4'd0, alu_opcode, alu_p}, {4'd0, m_ir[11:0]});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; imem_data = 16'h0000;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h00] = 16'h1080;
    mem[8'h01] = 16'h10FF;
    mem[8'h02] = {4'd0, OP_ADDWP, 8'h01};
    mem[8'h03] = 16'h1000;
    mem[8'h04] = 16'h3040;
    mem[8'h40] = 16'h1001;
    mem[8'h41] = 16'h3040;
    mem[8'h42] = 16'h20FF;
    mem[8'hFF] = 16'h7000;
    model_reset();
    cyc();
    do_reset();

    run_instr(0, 1'b0);
    chk("ldi80_wreg",   {8'd0, wreg},    16'h0080);
    chk("ldi80_status", {13'd0, status}, 16'h0002);
    chk("ldi80_pc",     {8'd0, pc},      16'h0001);
    run_instr(3, 1'b1);
    run_instr(0, 1'b1);
    chk("add_wreg",   {8'd0, wreg},    16'h0000);
    chk("add_status", {13'd0, status}, 16'h0005);
    run_instr(1, 1'b0);
    run_instr(0, 1'b0);
    chk("jz_taken_pc", {8'd0, pc}, 16'h0040);
    run_instr(2, 1'b1);
    run_instr(0, 1'b0);
    chk("jz_fall_pc", {8'd0, pc}, 16'h0042);
    run_instr(0, 1'b0);
    chk("jmp_pc", {8'd0, pc}, 16'h00FF);
    run_instr(1, 1'b1);
    chk("wrap_pc",   {8'd0, pc},   16'h0000);
    chk("wrap_wreg", {8'd0, wreg}, 16'h0001);

    // HALT program
    mem[8'h00] = 16'h105A;
    mem[8'h01] = {4'd0, OP_ADDWP, 8'h01};
    mem[8'h02] = 16'h6000;
    do_reset();
    run_instr(0, 1'b0);
    run_instr(2, 1'b1);
    run_instr(1, 1'b0);
    chk("halt_flag", {15'd0, halted}, 16'h0001);
    for (int k = 0; k < 6; k++) begin
      imem_ack  = 1'($urandom);
      imem_data = 16'($urandom);
      cyc();
      chk("halt_req",  {15'd0, imem_req}, 16'h0000);
      chk("halt_hold", {15'd0, halted},   16'h0001);
      chk("halt_pc",   {8'd0, pc},        16'h0003);
      chk("halt_wreg", {8'd0, wreg},      16'h005B);
    end
    imem_ack = 1'b0;
    do_reset();
    chk("unhalt", {15'd0, halted}, 16'h0000);
    run_instr(0, 1'b0);

    // reset while a fetch is waiting
    run_instr(0, 1'b0);
    imem_ack = 1'b0;
    cyc();
    cyc();
    chk("midwait_req", {15'd0, imem_req}, 16'h0001);
    do_reset();
    run_instr(1, 1'b0);

    // random programs, no HALT, random wait states and stray acks
    for (int pgm = 0; pgm < 4; pgm++) begin
      for (int i = 0; i < 256; i++) begin
        mem[i] = 16'($urandom);
        if (mem[i][15:12] == 4'd6) mem[i][15:12] = 4'd0;
        if (mem[i][15:12] > 4'd7) mem[i][15:12] = 4'($urandom_range(0, 5));
      end
      do_reset();
      for (int n = 0; n < 40; n++)
        run_instr(int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
